// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// and the per-op latency select.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MADD  = 3'd4;
  localparam logic [2:0] MD_MADDU = 3'd5;
  localparam logic [2:0] MD_MSUB  = 3'd6;
  localparam logic [2:0] MD_MSUBU = 3'd7;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Divides take the long latency; every multiply flavour takes the short one.
  function automatic int md_lat_sel(input logic [2:0] op, input int mult_lat,
                                    input int div_lat);
    if (op == MD_DIV || op == MD_DIVU) return div_lat;
    return mult_lat;
  endfunction

endpackage

// File: rtl/md_countdown.sv
// Loadable down-counter: remain counts to zero, busy while non-zero,
// last marks the final cycle before the result is committed.
module md_countdown #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic [CNT_W-1:0] remain,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] remain_d, remain_q;

  always_comb begin
    remain_d = remain_q;
    if (clear) begin
      remain_d = '0;
    end else if (load) begin
      remain_d = load_val;
    end else if (remain_q != '0) begin
      remain_d = remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) remain_q <= '0;
    else       remain_q <= remain_d;
  end

  assign remain = remain_q;
  assign busy   = (remain_q != '0);
  assign last   = (remain_q == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = $clog2(((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             cancel,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [CNT_W-1:0] remain,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  md_state_e state_d, state_q;
  logic [WIDTH-1:0] hi_d, hi_q, lo_d, lo_q;
  logic [W2-1:0]    res_d, res_q;
  logic             div_zero_d, div_zero_q;

  logic legal, accept, commit, write_ok;
  logic cnt_busy, cnt_last;
  logic [CNT_W-1:0] cnt_remain;

  // Sign-magnitude divide so truncation toward zero and the remainder sign
  // fall out naturally; most-negative / -1 yields {0, most-negative}.
  // A zero divisor is replaced by one only to keep the value defined; the
  // result is discarded at commit.
  function automatic logic [W2-1:0] divide(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, q, r;
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    mag_a = neg_a ? (~a + WIDTH'(1)) : a;
    mag_b = neg_b ? (~b + WIDTH'(1)) : b;
    if (mag_b == '0) mag_b = WIDTH'(1);
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (neg_a ^ neg_b) q = ~q + WIDTH'(1);
    if (neg_a)         r = ~r + WIDTH'(1);
    return {r, q};
  endfunction

  // Operand-side arithmetic, latched into res_q at the accept edge
  logic signed [W2-1:0] a_ext_s, b_ext_s, prod_s;
  logic        [W2-1:0] prod_u, prod;
  logic                 op_signed, op_div;

  always_comb begin
    op_signed = ~op[0];
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    a_ext_s   = W2'($signed(src_a));
    b_ext_s   = W2'($signed(src_b));
    prod_s    = a_ext_s * b_ext_s;
    prod_u    = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    prod      = op_signed ? $unsigned(prod_s) : prod_u;
  end

`ifdef MD_MADD_EN
  logic [W2-1:0] acc;
  always_comb begin
    acc = op[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  end
  assign legal = 1'b1;
`else
  assign legal = ~op[2];
`endif

  always_comb begin
    res_d      = res_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      div_zero_d = op_div && (src_b == '0);
      if (op_div) begin
        res_d = divide(src_a, src_b, op_signed);
`ifdef MD_MADD_EN
      end else if (op[2]) begin
        res_d = acc;
`endif
      end else begin
        res_d = prod;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_RUN;
      MD_RUN:  if (flush || cnt_last) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM: outputs; a write coinciding with an accepted start loses to it
  always_comb begin
    accept   = 1'b0;
    commit   = 1'b0;
    write_ok = 1'b0;
    case (state_q)
      MD_IDLE: begin
        accept   = start && !cancel && !flush && legal;
        write_ok = !cancel && !cnt_busy && !accept;
      end
      MD_RUN:  commit = cnt_last && !flush;
      default: ;
    endcase
  end

  md_countdown #(
    .CNT_W(CNT_W)
  ) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CNT_W'(md_lat_sel(op, MULT_LAT, DIV_LAT))),
    .clear    (flush),
    .remain   (cnt_remain),
    .busy     (cnt_busy),
    .last     (cnt_last)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (!div_zero_q) {hi_d, lo_d} = res_q;
    end else if (write_ok) begin
      if (hi_we) hi_d = src_a;
      if (lo_we) lo_d = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Result staging is pure data and only consumed at commit
  always_ff @(posedge clk) begin
    res_q      <= res_d;
    div_zero_q <= div_zero_d;
  end

  assign busy   = cnt_busy;
  assign remain = cnt_remain;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers, living in the E stage of the 5-stage pipeline.
- Successor of the fixed 32-bit MAD block, adding:
  - configurable width and latencies;
  - a pipeline-flush abort of in-flight operations;
  - signed-overflow/divide-by-zero rules;
  - a remaining-cycle counter for hazard logic.
- The hazard unit stalls D-stage MD instructions while busy is set or start is set.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_LAT, 5: cycles from start accepted to HI/LO update for multiply ops (>=1).
- DIV_LAT, 10: cycles from start accepted to HI/LO update for divide ops (>=1).
- CNT_W, $clog2(max(MULT_LAT,DIV_LAT)+1): counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation `op` this cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- hi_we  in  1  MTHI: HI <= src_a.
- lo_we  in  1  MTLO: LO <= src_a.
- cancel  in  1  exception/interrupt in E this cycle; suppresses start/hi_we/lo_we this cycle.
- flush  in  1  abort any in-flight op; HI/LO keep pre-op values.
- src_a  in  WIDTH  rs operand (forwarded).
- src_b  in  WIDTH  rt operand (forwarded).
- busy  out  1  operation in flight.
- remain  out  CNT_W  cycles left until HI/LO update; 0 when idle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, clk edge with reset=1): hi=0, lo=0, busy=0, remain=0, state IDLE. Any in-flight op is dropped.
- States: IDLE, RUN.
- IDLE -> RUN when start & !cancel & !flush & op legal.
  - Operands are latched and the result is computed into internal res_hi/res_lo.
  - remain loads MULT_LAT (op 0,1,4-7) or DIV_LAT (op 2,3).
  - busy goes 1 the following cycle.
- RUN: remain decrements each cycle.
  - On the cycle remain==1: next edge writes hi/lo from res, busy=0, remain=0, back to IDLE.
  - New hi/lo are visible exactly LAT cycles after the start edge.
- start while busy: ignored. Hazard logic must prevent this; the bench flags it as an error.
- flush in RUN: next edge -> IDLE, busy=0, remain=0, hi/lo unchanged.
- flush in IDLE: blocks a same-cycle start.
- hi_we/lo_we:
  - Take effect on the next edge when !cancel & !busy.
  - Ignored while busy.
  - If they coincide with a start, the start wins and the write is ignored.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
  - DIV/DIVU: lo = quotient, hi = remainder; truncation toward zero; remainder sign follows dividend.
  - Signed DIV with src_a = most-negative and src_b = -1: lo = most-negative, hi = 0.
  - Divide by zero (DIV/DIVU): runs full DIV_LAT, then hi/lo unchanged.
  - MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- product.
    - {hi,lo} are sampled at the start edge; wraps modulo 2^(2*WIDTH).
- Reset mid-operation overrides flush, cancel, and start.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 4-7 are legal as above.
- Undefined: ops 4-7 are illegal; start with op>=4 is ignored (stays IDLE, no busy), and the accumulate datapath is not synthesised.

Decomposition:
- Package md_pkg:
  - op encoding constants MD_MULT..MD_MSUBU;
  - state enum MD_IDLE/MD_RUN;
  - helper function for the latency select.
- One sub-module, md_countdown: loadable down-counter producing remain/busy/last-cycle strobe, parametrised by CNT_W.

Test Plan:
- MULT src_a=-3, src_b=7, default params: busy=1 for 5 cycles; remain 5..1; then hi=FFFFFFFF, lo=FFFFFFEB.
- DIVU 100/7: after 10 cycles lo=14, hi=2. Signed DIV -7/2: lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF: lo=80000000, hi=0.
- Preload hi=1, lo=2 via MTHI/MTLO; DIV 5/0: after 10 cycles hi=1, lo=2, busy=0.
- MULTU FFFFFFFF*2 started, flush on 3rd busy cycle: busy drops next edge; hi/lo keep prior values; no later update.
- start+cancel same cycle: no busy. MTLO while busy: ignored. MTHI on idle cycle: hi=src_a next edge.
- With MD_MADD_EN, hi=0, lo=FFFFFFFF, MADDU 1*1: hi=1, lo=0. Without macro: same start leaves busy=0 and hi/lo unchanged.
